// File: rtl/calc_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : calc_key_scheduler
//  Description : Arbitrates key events from the keypad and an auxiliary/replay
//                requester into a FIFO. Each buffered key is replayed to the
//                calculator core as a paced key_pressed pulse with a stable
//                keypad_out, so that the core's edge detector and multi-cycle
//                states settle before the next key arrives.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH  : key buffer entries (power of 2, >= 2)
//    HOLD_CYCLES : cycles key_pressed stays high per key (>= 1)
//    GAP_CYCLES  : low cycles after each key before the next pop (>= 1)
//  Ports
//    clk, reset          : clock, synchronous active-high reset
//    kp_valid/code/ready : keypad requester handshake (5-bit code)
//    aux_valid/code/ready: auxiliary requester handshake (5-bit code)
//    key_pressed         : registered key strobe to the core
//    keypad_out          : registered 25-bit key code (zero-extended)
//    fifo_count          : current FIFO occupancy
//    busy                : FIFO non-empty or pulse engine not idle
//  Build option
//    KEYSCHED_DROP_INVALID_EN : when defined, accepted codes >= 5'h10 are
//                               consumed by the handshake but not enqueued.
// ============================================================================
module calc_key_scheduler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              kp_valid,
    input  logic [4:0]                        kp_code,
    output logic                              kp_ready,
    input  logic                              aux_valid,
    input  logic [4:0]                        aux_code,
    output logic                              aux_ready,
    output logic                              key_pressed,
    output logic [24:0]                       keypad_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_max_cyc = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_tmr_w = $clog2(c_max_cyc + 1);

    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_tmr_w-1:0] c_hold_ld  = c_tmr_w'(HOLD_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_gap_ld   = c_tmr_w'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [4:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_rr_aux;      // 1: auxiliary wins the next contest
    state_t              r_state;
    logic [c_tmr_w-1:0]  r_tmr;
    logic                r_key_pressed;
    logic [4:0]          r_code;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                w_full;
    logic                w_kp_ready;
    logic                w_aux_ready;
    logic                w_rr_flip;
    logic                w_kp_take;
    logic                w_aux_take;
    logic                w_accept;
    logic [4:0]          w_code;
    logic                w_push;
    logic                w_pop;
    state_t              w_state_nxt;
    logic [c_tmr_w-1:0]  w_tmr_nxt;
    logic                w_key_pressed_nxt;
    logic [4:0]          w_code_nxt;

    // Full is taken from the registered (pre-pop) count, so a pop in the
    // same cycle never opens a slot for a push.
    assign w_full = (r_count == c_full_cnt);

    // ------------------------------------------------------------------------
    // Arbitration: one accept per cycle, round-robin only on contention
    // ------------------------------------------------------------------------
    always_comb begin
        w_kp_ready  = 1'b0;
        w_aux_ready = 1'b0;
        w_rr_flip   = 1'b0;
        if (!w_full) begin
            if (kp_valid && aux_valid) begin
                w_rr_flip = 1'b1;
                if (r_rr_aux) begin
                    w_aux_ready = 1'b1;
                end else begin
                    w_kp_ready = 1'b1;
                end
            end else begin
                w_kp_ready  = kp_valid;
                w_aux_ready = aux_valid;
            end
        end
    end

    assign w_kp_take  = kp_valid  && w_kp_ready;
    assign w_aux_take = aux_valid && w_aux_ready;
    assign w_accept   = w_kp_take || w_aux_take;
    assign w_code     = w_aux_take ? aux_code : kp_code;

`ifdef KEYSCHED_DROP_INVALID_EN
    // Codes with bit 4 set complete the handshake but are silently dropped.
    assign w_push = w_accept && !w_code[4];
`else
    assign w_push = w_accept;
`endif

    assign w_pop = (r_state == ST_IDLE) && (r_count != '0);

    // ------------------------------------------------------------------------
    // FIFO storage (data array needs no reset; pointers/count guard it)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_aux <= 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap naturally on overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_rr_flip) begin
                r_rr_aux <= ~r_rr_aux;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pulse engine: IDLE -> ASSERT (HOLD_CYCLES) -> GAP (GAP_CYCLES) -> IDLE
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tmr         <= '0;
            r_key_pressed <= 1'b0;
            r_code        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_tmr         <= w_tmr_nxt;
            r_key_pressed <= w_key_pressed_nxt;
            r_code        <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_tmr_nxt         = r_tmr;
        w_key_pressed_nxt = r_key_pressed;
        w_code_nxt        = r_code;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_code_nxt        = r_mem[r_rd_ptr];
                    w_key_pressed_nxt = 1'b1;
                    w_tmr_nxt         = c_hold_ld;
                    w_state_nxt       = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (r_tmr == '0) begin
                    w_key_pressed_nxt = 1'b0;
                    w_tmr_nxt         = c_gap_ld;
                    w_state_nxt       = ST_GAP;
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_tmr == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
            default: begin
                w_state_nxt       = ST_IDLE;
                w_key_pressed_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign kp_ready    = w_kp_ready;
    assign aux_ready   = w_aux_ready;
    assign key_pressed = r_key_pressed;
    assign keypad_out  = {20'b0, r_code};
    assign fifo_count  = r_count;
    assign busy        = (r_count != '0) || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_calc_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_key_scheduler
//  Description : Self-checking bench for calc_key_scheduler. A queue plus
//                edge-number arithmetic predicts readys, pulse timing,
//                keypad_out, occupancy and busy every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_key_scheduler;

    localparam int D = 8;
    localparam int H = 4;
    localparam int G = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        kp_valid, aux_valid;
    logic [4:0]  kp_code, aux_code;
    logic        kp_ready, aux_ready;
    logic        key_pressed;
    logic [24:0] keypad_out;
    logic [3:0]  fifo_count;
    logic        busy;

    calc_key_scheduler #(
        .FIFO_DEPTH  (D),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .kp_valid    (kp_valid),
        .kp_code     (kp_code),
        .kp_ready    (kp_ready),
        .aux_valid   (aux_valid),
        .aux_code    (aux_code),
        .aux_ready   (aux_ready),
        .key_pressed (key_pressed),
        .keypad_out  (keypad_out),
        .fifo_count  (fifo_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Requester intent (held until granted)
    logic       kv, av;
    logic [4:0] kc, ac;

    // Reference model state
    int q[$];
    int m_rr;        // 0: keypad wins next contest, 1: auxiliary
    int e;           // number of clock edges seen
    int idle_from;   // first edge at which a pop may occur
    int last_pop;    // edge at which the latest pop happened
    int m_out;       // code currently presented on keypad_out
    bit g_kp, g_aux; // model's grants for the current cycle

    int n_checks;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit keep(input int code);
`ifdef KEYSCHED_DROP_INVALID_EN
        return code < 16;
`else
        return 1'b1;
`endif
    endfunction

    // One clock cycle: drive, check readys, advance model on the edge,
    // check registered outputs shortly after the edge.
    task automatic step(input bit rst_in);
        int code;
        reset     = rst_in;
        kp_valid  = kv;
        kp_code   = kc;
        aux_valid = av;
        aux_code  = ac;
        #1;
        g_kp  = 1'b0;
        g_aux = 1'b0;
        if (!rst_in) begin
            if (q.size() < D) begin
                if (kv && av) begin
                    if (m_rr != 0) g_aux = 1'b1;
                    else           g_kp  = 1'b1;
                    m_rr = 1 - m_rr;
                end else begin
                    g_kp  = kv;
                    g_aux = av;
                end
            end
            chk("kp_ready", {31'b0, kp_ready}, {31'b0, g_kp});
            chk("aux_ready", {31'b0, aux_ready}, {31'b0, g_aux});
        end
        @(posedge clk);
        e++;
        if (rst_in) begin
            q.delete();
            m_rr      = 0;
            idle_from = 0;
            last_pop  = -100;
            m_out     = 0;
        end else begin
            if (q.size() > 0 && e >= idle_from) begin
                m_out     = q.pop_front();
                last_pop  = e;
                idle_from = e + H + G + 1;
            end
            if (g_kp || g_aux) begin
                code = g_kp ? int'(kc) : int'(ac);
                if (keep(code)) q.push_back(code);
            end
        end
        #1;
        chk("key_pressed", {31'b0, key_pressed},
            {31'b0, (e >= last_pop) && (e < last_pop + H)});
        chk("keypad_out", {7'b0, keypad_out}, m_out);
        chk("fifo_count", {28'b0, fifo_count}, q.size());
        chk("busy", {31'b0, busy}, {31'b0, (q.size() != 0) || (e < idle_from - 1)});
        @(negedge clk);
    endtask

    task automatic push_kp(input logic [4:0] code);
        int n;
        kv = 1'b1;
        kc = code;
        n  = 0;
        do begin
            step(1'b0);
            n++;
        end while (!g_kp && n < 200);
        if (!g_kp) begin
            n_checks++;
            n_err++;
            $error("FAIL push_timeout observed=%0d expected=grant", n);
        end
        kv = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        kv = 1'b0;
        av = 1'b0;
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic do_reset();
        kv = 1'b0;
        av = 1'b0;
        step(1'b1);
        step(1'b1);
    endtask

    initial begin
        int nk, na;
        n_checks = 0;
        n_err    = 0;
        e = 0; m_rr = 0; idle_from = 0; last_pop = -100; m_out = 0;
        kv = 0; av = 0; kc = 0; ac = 0;
        reset = 1'b1; kp_valid = 0; aux_valid = 0; kp_code = 0; aux_code = 0;
        @(negedge clk);

        // Power-on reset
        do_reset();

        // T2: single key into an idle block
        push_kp(5'h7);
        idle_cycles(12);

        // T1: reset while the pulse is asserted
        push_kp(5'h5);
        idle_cycles(2);
        do_reset();
        idle_cycles(3);

        // T3: contested requests, codes 1 (keypad) and 2 (auxiliary)
        do_reset();
        kv = 1'b1; kc = 5'h1;
        av = 1'b1; ac = 5'h2;
        nk = 0; na = 0;
        for (int i = 0; i < 20 && (kv || av); i++) begin
            step(1'b0);
            if (g_kp)  begin nk++; if (nk == 2) kv = 1'b0; end
            if (g_aux) begin na++; if (na == 2) av = 1'b0; end
        end
        idle_cycles(40);

        // T4: fill the FIFO while the pulse engine is busy
        do_reset();
        for (int i = 0; i < 9; i++) push_kp(5'(i + 3));
        chk("t4_full_count", {28'b0, fifo_count}, D);
        push_kp(5'hA);  // held through the full window, accepted after a pop
        idle_cycles(90);

        // T5: stream 20 keys through the depth-8 FIFO with wraparound
        do_reset();
        for (int i = 0; i < 20; i++) push_kp(5'(i % 16));
        idle_cycles(200);

        // T6: out-of-range code
        do_reset();
        push_kp(5'h12);
        idle_cycles(12);

        // Randomised traffic on both requesters, one reset mid-stream
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!kv && $urandom_range(0, 2) == 0) begin
                kv = 1'b1;
                kc = 5'($urandom_range(0, 31));
            end
            if (!av && $urandom_range(0, 2) == 0) begin
                av = 1'b1;
                ac = 5'($urandom_range(0, 31));
            end
            if (i == 200) begin
                kv = 1'b0;
                av = 1'b0;
                step(1'b1);
            end else begin
                step(1'b0);
            end
            if (g_kp)  kv = 1'b0;
            if (g_aux) av = 1'b0;
        end
        idle_cycles(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
